// File: rtl/rx_req_completer.sv
// Read-completion engine: answers one RX read request at a time with incrementing address words.
// Optional error injection is enabled with the RX_REQ_COMPLETER_ERR_INJECT_EN macro.
`ifndef DATA_WIDTH
`define DATA_WIDTH 128
`endif

module rx_req_completer #(
  parameter int C_DATA_WIDTH      = `DATA_WIDTH,
  parameter int C_DATA_WORD_WIDTH = $clog2((C_DATA_WIDTH/32)+1),
  parameter int C_GAP_EVERY       = 0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         RX_REQ,
  output logic                         RX_REQ_ACK,
  input  logic [1:0]                   RX_REQ_TAG,
  input  logic [63:0]                  RX_REQ_ADDR,
  input  logic [9:0]                   RX_REQ_LEN,
`ifdef RX_REQ_COMPLETER_ERR_INJECT_EN
  input  logic                         ERR_INJECT,
`endif
  output logic [C_DATA_WIDTH-1:0]      ENG_DATA,
  output logic [C_DATA_WORD_WIDTH-1:0] MAIN_DATA_EN,
  output logic [C_DATA_WORD_WIDTH-1:0] SG_RX_DATA_EN,
  output logic [C_DATA_WORD_WIDTH-1:0] SG_TX_DATA_EN,
  output logic                         MAIN_DONE,
  output logic                         SG_RX_DONE,
  output logic                         SG_TX_DONE,
  output logic                         MAIN_ERR,
  output logic                         SG_RX_ERR,
  output logic                         SG_TX_ERR
);

  // state | meaning
  // IDLE  | waiting for RX_REQ, latches tag/addr/len
  // ACK   | one-cycle request accept
  // DATA  | emitting data beats (and gap beats)
  // DONE  | one-cycle completion pulse on the selected channel
  typedef enum logic [1:0] {IDLE, ACK, DATA, DONE} state_t;

  localparam int          W      = C_DATA_WIDTH/32;
  localparam logic [10:0] W_L    = 11'(W);
  localparam logic [15:0] GAP_L  = 16'(C_GAP_EVERY);

  state_t      state_q, state_d;
  logic [1:0]  tag_q, tag_d;
  logic [31:0] addr_q, addr_d;
  logic [10:0] rem_q, rem_d;
  logic [15:0] gap_q, gap_d;
  logic        gap_pend_q, gap_pend_d;
  logic        err_q, err_d;

  logic [10:0] beat_words;
  logic [10:0] rem_after;
  logic [C_DATA_WORD_WIDTH-1:0] en_val;
  logic        beat_active;
  logic        done_active;
  logic        inj;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^RX_REQ_ADDR[63:32];

`ifdef RX_REQ_COMPLETER_ERR_INJECT_EN
  assign inj = ERR_INJECT;
`else
  assign inj = 1'b0;
`endif

  assign beat_words = (rem_q > W_L) ? W_L : rem_q;
  assign rem_after  = rem_q - beat_words;
  assign en_val     = C_DATA_WORD_WIDTH'(beat_words);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      tag_q      <= 2'b00;
      addr_q     <= 32'h0;
      rem_q      <= 11'h0;
      gap_q      <= 16'h0;
      gap_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      gap_q      <= gap_d;
      gap_pend_q <= gap_pend_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    gap_d       = gap_q;
    gap_pend_d  = gap_pend_q;
    err_d       = err_q;
    RX_REQ_ACK  = 1'b0;
    beat_active = 1'b0;
    done_active = 1'b0;

    case (state_q)
      IDLE: begin
        if (RX_REQ) begin
          state_d    = ACK;
          tag_d      = RX_REQ_TAG;
          addr_d     = RX_REQ_ADDR[31:0];
          rem_d      = (RX_REQ_LEN == 10'd0) ? 11'd1024 : {1'b0, RX_REQ_LEN};
          gap_d      = GAP_L;
          gap_pend_d = 1'b0;
          err_d      = 1'b0;
        end
      end
      ACK: begin
        RX_REQ_ACK = 1'b1;
        err_d      = inj;
        state_d    = (tag_q == 2'b11) ? IDLE : DATA;
      end
      DATA: begin
        if (gap_pend_q) begin
          gap_pend_d = 1'b0;
        end else begin
          beat_active = 1'b1;
          addr_d      = addr_q + 32'(4*W);
          rem_d       = rem_after;
          // Completion (or truncation) wins over a pending gap so no gap follows the last beat.
          if (rem_after == 11'd0 || err_q) begin
            state_d = DONE;
          end else if (C_GAP_EVERY > 0) begin
            if (gap_q == 16'd1) begin
              gap_pend_d = 1'b1;
              gap_d      = GAP_L;
            end else begin
              gap_d = gap_q - 16'd1;
            end
          end
        end
      end
      DONE: begin
        done_active = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ENG_DATA      = '0;
    MAIN_DATA_EN  = '0;
    SG_RX_DATA_EN = '0;
    SG_TX_DATA_EN = '0;
    MAIN_DONE     = 1'b0;
    SG_RX_DONE    = 1'b0;
    SG_TX_DONE    = 1'b0;
    MAIN_ERR      = 1'b0;
    SG_RX_ERR     = 1'b0;
    SG_TX_ERR     = 1'b0;

    if (beat_active) begin
      for (int j = 0; j < W; j++) begin
        if (11'(j) < beat_words) ENG_DATA[j*32 +: 32] = addr_q + 32'(4*j);
      end
      case (tag_q)
        2'b00:   MAIN_DATA_EN  = en_val;
        2'b01:   SG_RX_DATA_EN = en_val;
        2'b10:   SG_TX_DATA_EN = en_val;
        default: ;
      endcase
    end

    if (done_active) begin
      case (tag_q)
        2'b00:   begin MAIN_DONE  = 1'b1; MAIN_ERR  = err_q; end
        2'b01:   begin SG_RX_DONE = 1'b1; SG_RX_ERR = err_q; end
        2'b10:   begin SG_TX_DONE = 1'b1; SG_TX_ERR = err_q; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_req_completer.sv
// Directed bench for rx_req_completer (128-bit bus): a plain instance and a gap-every-2 instance
// share clock and reset; per-cycle expected outputs are queued at request time.
module tb_rx_req_completer;

  typedef struct packed {
    logic [2:0]   m_en;
    logic [2:0]   r_en;
    logic [2:0]   t_en;
    logic         m_done;
    logic         r_done;
    logic         t_done;
    logic         m_err;
    logic         r_err;
    logic         t_err;
    logic [127:0] data;
  } obs_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic         req_a, ack_a, req_b, ack_b;
  logic [1:0]   tag_a, tag_b;
  logic [63:0]  addr_a, addr_b;
  logic [9:0]   len_a, len_b;
  logic [127:0] data_a, data_b;
  logic [2:0]   men_a, ren_a, ten_a, men_b, ren_b, ten_b;
  logic         mdone_a, rdone_a, tdone_a, mdone_b, rdone_b, tdone_b;
  logic         merr_a, rerr_a, terr_a, merr_b, rerr_b, terr_b;
`ifdef RX_REQ_COMPLETER_ERR_INJECT_EN
  logic         err_inj;
`endif

  int total = 0;
  int bad   = 0;
  obs_t exp_q[$];

  rx_req_completer #(.C_DATA_WIDTH(128), .C_GAP_EVERY(0)) dut_a (
    .CLK(CLK), .RST(RST), .RX_REQ(req_a), .RX_REQ_ACK(ack_a), .RX_REQ_TAG(tag_a),
    .RX_REQ_ADDR(addr_a), .RX_REQ_LEN(len_a),
`ifdef RX_REQ_COMPLETER_ERR_INJECT_EN
    .ERR_INJECT(err_inj),
`endif
    .ENG_DATA(data_a), .MAIN_DATA_EN(men_a), .SG_RX_DATA_EN(ren_a), .SG_TX_DATA_EN(ten_a),
    .MAIN_DONE(mdone_a), .SG_RX_DONE(rdone_a), .SG_TX_DONE(tdone_a),
    .MAIN_ERR(merr_a), .SG_RX_ERR(rerr_a), .SG_TX_ERR(terr_a));

  rx_req_completer #(.C_DATA_WIDTH(128), .C_GAP_EVERY(2)) dut_b (
    .CLK(CLK), .RST(RST), .RX_REQ(req_b), .RX_REQ_ACK(ack_b), .RX_REQ_TAG(tag_b),
    .RX_REQ_ADDR(addr_b), .RX_REQ_LEN(len_b),
`ifdef RX_REQ_COMPLETER_ERR_INJECT_EN
    .ERR_INJECT(1'b0),
`endif
    .ENG_DATA(data_b), .MAIN_DATA_EN(men_b), .SG_RX_DATA_EN(ren_b), .SG_TX_DATA_EN(ten_b),
    .MAIN_DONE(mdone_b), .SG_RX_DONE(rdone_b), .SG_TX_DONE(tdone_b),
    .MAIN_ERR(merr_b), .SG_RX_ERR(rerr_b), .SG_TX_ERR(terr_b));

  function automatic obs_t observe(input int sel);
    obs_t o;
    if (sel == 0) o = '{men_a, ren_a, ten_a, mdone_a, rdone_a, tdone_a, merr_a, rerr_a, terr_a, data_a};
    else          o = '{men_b, ren_b, ten_b, mdone_b, rdone_b, tdone_b, merr_b, rerr_b, terr_b, data_b};
    return o;
  endfunction

  function automatic logic ack_of(input int sel);
    return (sel == 0) ? ack_a : ack_b;
  endfunction

  // Build the expected per-cycle output stream, drive the request and check ACK latency.
  task automatic issue(input int sel, input logic [1:0] tag, input logic [63:0] addr, input int len,
                       input int gap, input bit inj, input bit hold, input int exp_lat, input string name);
    int   L, nb, cnt, lat;
    bit   got;
    obs_t r;
    L  = (len == 0) ? 1024 : len;
    nb = (L + 3) / 4;
    if (inj) nb = 1;
    if (tag != 2'b11) begin
      for (int b = 0; b < nb; b++) begin
        r   = '0;
        cnt = (L - 4*b > 4) ? 4 : L - 4*b;
        for (int j = 0; j < cnt; j++) r.data[j*32 +: 32] = addr[31:0] + 32'(4*(4*b + j));
        case (tag)
          2'b00:   r.m_en = 3'(cnt);
          2'b01:   r.r_en = 3'(cnt);
          default: r.t_en = 3'(cnt);
        endcase
        exp_q.push_back(r);
        if (gap > 0 && (b + 1) % gap == 0 && b != nb - 1) exp_q.push_back('0);
      end
      r = '0;
      case (tag)
        2'b00:   begin r.m_done = 1'b1; r.m_err = inj; end
        2'b01:   begin r.r_done = 1'b1; r.r_err = inj; end
        default: begin r.t_done = 1'b1; r.t_err = inj; end
      endcase
      exp_q.push_back(r);
    end
    if (sel == 0) begin req_a = 1'b1; tag_a = tag; addr_a = addr; len_a = 10'(len); end
    else          begin req_b = 1'b1; tag_b = tag; addr_b = addr; len_b = 10'(len); end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge CLK);
      lat++;
      if (ack_of(sel)) got = 1'b1;
    end
    total++;
    assert (got && lat == exp_lat) else begin
      bad++;
      $error("FAIL ack_lat_%s observed=%0d expected=%0d (seen=%0d)", name, lat, exp_lat, got);
    end
    if (!hold) begin
      if (sel == 0) req_a = 1'b0; else req_b = 1'b0;
    end
`ifdef RX_REQ_COMPLETER_ERR_INJECT_EN
    if (sel == 0) begin
      err_inj = inj;
      @(posedge CLK);
      #1 err_inj = 1'b0;
    end
`endif
  endtask

  task automatic drain(input int sel, input int n, input string name);
    int   k;
    obs_t e, o;
    k = 0;
    while (exp_q.size() > 0 && (n < 0 || k < n)) begin
      @(negedge CLK);
      e = exp_q.pop_front();
      o = observe(sel);
      total++;
      assert (o === e) else begin
        bad++;
        $error("FAIL %s[%0d] observed=%h expected=%h", name, k, o, e);
      end
      k++;
    end
  endtask

  task automatic check_idle(input int sel, input string name);
    obs_t o;
    @(negedge CLK);
    o = observe(sel);
    total++;
    assert (o === obs_t'('0) && ack_of(sel) === 1'b0) else begin
      bad++;
      $error("FAIL idle_%s observed=%h ack=%b expected=0", name, o, ack_of(sel));
    end
  endtask

  initial begin
    RST = 1'b1;
    req_a = 1'b0; tag_a = 2'b00; addr_a = '0; len_a = '0;
    req_b = 1'b0; tag_b = 2'b00; addr_b = '0; len_b = '0;
`ifdef RX_REQ_COMPLETER_ERR_INJECT_EN
    err_inj = 1'b0;
`endif
    repeat (2) @(negedge CLK);
    check_idle(0, "reset_a");
    check_idle(1, "reset_b");
    RST = 1'b0;
    check_idle(0, "post_reset");

    issue(0, 2'b00, 64'h0000_0000_0000_1000, 6, 0, 1'b0, 1'b0, 1, "main6");
    drain(0, -1, "main6");
    check_idle(0, "main6_after");

    issue(0, 2'b01, 64'h0000_0000_0000_2000, 0, 0, 1'b0, 1'b0, 1, "sgrx1024");
    drain(0, -1, "sgrx1024");
    check_idle(0, "sgrx_after");

    issue(0, 2'b10, 64'hDEAD_BEEF_FFFF_FFF8, 4, 0, 1'b0, 1'b0, 1, "sgtx_wrap");
    drain(0, -1, "sgtx_wrap");
    check_idle(0, "sgtx_after");

    issue(1, 2'b00, 64'h0000_0000_0000_0040, 16, 2, 1'b0, 1'b0, 1, "gap16");
    drain(1, -1, "gap16");
    check_idle(1, "gap16_after");

    issue(1, 2'b11, 64'h0000_0000_0000_0080, 5, 2, 1'b0, 1'b0, 1, "discard");
    check_idle(1, "discard_1");
    check_idle(1, "discard_2");

    issue(0, 2'b00, 64'h0000_0000_0000_3000, 64, 0, 1'b0, 1'b0, 1, "rst64");
    drain(0, 3, "rst64");
    RST = 1'b1;
    check_idle(0, "rst_mid");
    RST = 1'b0;
    exp_q.delete();
    check_idle(0, "rst_no_done_1");
    check_idle(0, "rst_no_done_2");

    issue(0, 2'b00, 64'h0000_0000_0000_5000, 1, 0, 1'b0, 1'b0, 1, "len1");
    drain(0, -1, "len1");
    check_idle(0, "len1_after");

    issue(0, 2'b01, 64'h0000_0000_0000_7000, 3, 0, 1'b0, 1'b1, 1, "b2b_first");
    drain(0, -1, "b2b_first");
    issue(0, 2'b10, 64'h0000_0000_0000_7100, 5, 0, 1'b0, 1'b0, 2, "b2b_second");
    drain(0, -1, "b2b_second");
    check_idle(0, "b2b_after");

`ifdef RX_REQ_COMPLETER_ERR_INJECT_EN
    issue(0, 2'b00, 64'h0000_0000_0000_6000, 8, 0, 1'b1, 1'b0, 1, "err8");
    drain(0, -1, "err8");
    check_idle(0, "err8_after");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
